life_gen_engine: RTL and testbench

//  Game-of-Life next-generation engine, upstream of pixel_generator.
//  On start, it streams every row of the current-generation line BRAM (bank bank_sel).
//  It computes each next-generation row from a 3-row sliding window and writes the rows into the other bank.
//  It then flips bank_sel so the pixel generator displays the new generation.

---
 rtl/life_pkg.sv | 16 +
 rtl/life_row_rule.sv | 33 +++
 rtl/life_gen_engine.sv | 153 +++++++++++++++
 tb/tb_life_gen_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants and FSM state type for the Game-of-Life generation engine.
package life_pkg;

    localparam int unsigned X_SIZE     = 1280;
    localparam int unsigned Y_SIZE     = 720;
    localparam int unsigned Y_WIDTH    = $clog2(Y_SIZE);
    localparam int unsigned RD_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } life_state_e;

endpackage

// File: rtl/life_row_rule.sv
// Combinational Life rule for one row, given the rows above and below.
import life_pkg::*;

module life_row_rule #(
    parameter int unsigned X_SIZE = life_pkg::X_SIZE
) (
    input  logic [X_SIZE-1:0] above,
    input  logic [X_SIZE-1:0] cur,
    input  logic [X_SIZE-1:0] below,
    input  logic              wrap_en,
    output logic [X_SIZE-1:0] next
);

    for (genvar i = 0; i < X_SIZE; i++) begin : g_cell
        // Bit i+1 is the left neighbour (column x-1), bit i-1 the right one.
        localparam int unsigned LI = (i == X_SIZE - 1) ? 0 : i + 1;
        localparam int unsigned RI = (i == 0) ? X_SIZE - 1 : i - 1;

        logic       l_ok;
        logic       r_ok;
        logic [3:0] n;

        assign l_ok = (i != X_SIZE - 1) || wrap_en;
        assign r_ok = (i != 0) || wrap_en;

        assign n = 4'(above[i]) + 4'(below[i])
                 + (l_ok ? 4'(above[LI]) + 4'(cur[LI]) + 4'(below[LI]) : 4'd0)
                 + (r_ok ? 4'(above[RI]) + 4'(cur[RI]) + 4'(below[RI]) : 4'd0);

        assign next[i] = (n == 4'd3) || (cur[i] && (n == 4'd2));
    end

endmodule

// File: rtl/life_gen_engine.sv
// Streams the current generation through a 3-row window and writes the next
// generation into the other bank, then flips bank_sel.
import life_pkg::*;

module life_gen_engine #(
    parameter int unsigned X_SIZE  = life_pkg::X_SIZE,
    parameter int unsigned Y_SIZE  = life_pkg::Y_SIZE,
    parameter int unsigned Y_WIDTH = $clog2(Y_SIZE)
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               start,
    input  logic               wrap_en,
    output logic               busy,
    output logic               done,
    output logic               bank_sel,
    output logic [31:0]        gen_count,
    output logic               rd_en,
    output logic [Y_WIDTH-1:0] rd_addr,
    input  logic [X_SIZE-1:0]  rd_data,
    output logic               wr_en,
    output logic [Y_WIDTH-1:0] wr_addr,
    output logic [X_SIZE-1:0]  wr_data
);

    localparam int unsigned        CW       = Y_WIDTH + 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(Y_SIZE);
    localparam logic [Y_WIDTH-1:0] ROW_LAST = Y_WIDTH'(Y_SIZE - 1);

    life_state_e        state_q, state_d;
    logic               wrap_q;
    logic               rd_vld_q;
    logic               extra_q;
    logic               win_vld_q;
    logic               shift;
    logic [CW-1:0]      rd_cnt_q;
    logic [CW-1:0]      arr_cnt_q;
    logic [Y_WIDTH-1:0] wr_row_q;
    logic [X_SIZE-1:0]  above_q, cur_q, below_q, row0_q;
    logic [X_SIZE-1:0]  shift_in;
    logic [X_SIZE-1:0]  next_row;

    life_row_rule #(
        .X_SIZE(X_SIZE)
    ) u_rule (
        .above  (above_q),
        .cur    (cur_q),
        .below  (below_q),
        .wrap_en(wrap_q),
        .next   (next_row)
    );

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_READ;
            end
            ST_READ: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = (rd_cnt_q == '0) ? ROW_LAST : Y_WIDTH'(rd_cnt_q - 1'b1);
                if (rd_cnt_q == CNT_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (wr_en && (wr_addr == ROW_LAST)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arrival 0 is row Y_SIZE-1 (top halo); the extra shift supplies the bottom halo.
    always_comb begin
        shift    = rd_vld_q || extra_q;
        shift_in = '0;
        if (rd_vld_q) begin
            shift_in = ((arr_cnt_q == '0) && !wrap_q) ? '0 : rd_data;
        end else if (wrap_q) begin
            shift_in = row0_q;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wrap_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            extra_q   <= 1'b0;
            win_vld_q <= 1'b0;
            rd_cnt_q  <= '0;
            arr_cnt_q <= '0;
            wr_row_q  <= '0;
            above_q   <= '0;
            cur_q     <= '0;
            below_q   <= '0;
            row0_q    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            bank_sel  <= 1'b0;
            gen_count <= '0;
        end else begin
            rd_vld_q  <= rd_en;
            extra_q   <= rd_vld_q && (arr_cnt_q == CNT_LAST);
            // Window holds a full (r-1, r, r+1) triple from the third shift on.
            win_vld_q <= (rd_vld_q && (arr_cnt_q >= CW'(2))) || extra_q;
            wr_en     <= win_vld_q;

            if ((state_q == ST_IDLE) && start) begin
                wrap_q    <= wrap_en;
                rd_cnt_q  <= '0;
                arr_cnt_q <= '0;
                wr_row_q  <= '0;
            end
            if (state_q == ST_READ) rd_cnt_q <= rd_cnt_q + 1'b1;

            if (shift) begin
                above_q <= cur_q;
                cur_q   <= below_q;
                below_q <= shift_in;
            end
            if (rd_vld_q) begin
                arr_cnt_q <= arr_cnt_q + 1'b1;
                if (arr_cnt_q == CW'(1)) row0_q <= rd_data;
            end

            if (win_vld_q) begin
                wr_data  <= next_row;
                wr_addr  <= wr_row_q;
                wr_row_q <= wr_row_q + 1'b1;
            end

            if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
                bank_sel  <= ~bank_sel;
                gen_count <= gen_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench for life_gen_engine on an 8x6 board with a two-bank BRAM model.
module tb_life_gen_engine;

    localparam int X  = 8;
    localparam int Y  = 6;
    localparam int YW = 3;

    typedef logic [Y-1:0][X-1:0] board_t;

    localparam board_t BLINK_H = {8'h00, 8'h00, 8'h00, 8'b00111000, 8'h00, 8'h00};
    localparam board_t BLINK_V = {8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h00};
    localparam board_t CORNERS = {8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
    localparam board_t PATTERN = {8'h5A, 8'h3C, 8'h81, 8'h66, 8'h18, 8'hC3};
    localparam board_t GLIDER  = {8'h00, 8'h00, 8'h00, 8'hE0, 8'h20, 8'h40};

    logic          aclk = 1'b0;
    logic          areset, start, wrap_en;
    logic          busy, done, bank_sel, rd_en, wr_en;
    logic [31:0]   gen_count;
    logic [YW-1:0] rd_addr, wr_addr;
    logic [X-1:0]  rd_data, wr_data;

    logic [X-1:0]  mem [2][Y];
    logic          ld_req;
    logic          ld_bank;
    board_t        ld_board;

    int            n_checks = 0;
    int            n_errors = 0;
    logic          exp_bank;
    logic [31:0]   exp_gc;

    always #5 aclk = ~aclk;

    life_gen_engine #(
        .X_SIZE (X),
        .Y_SIZE (Y),
        .Y_WIDTH(YW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .start    (start),
        .wrap_en  (wrap_en),
        .busy     (busy),
        .done     (done),
        .bank_sel (bank_sel),
        .gen_count(gen_count),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always @(posedge aclk) begin
        if (rd_en) rd_data <= mem[bank_sel][rd_addr];
        if (wr_en) mem[~bank_sel][wr_addr] <= wr_data;
        if (ld_req) begin
            for (int r = 0; r < Y; r++) mem[ld_bank][r] <= ld_board[r];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic board_t get_board(input logic b);
        board_t bd;
        for (int r = 0; r < Y; r++) bd[r] = mem[b][r];
        return bd;
    endfunction

    function automatic board_t life_step(input board_t b, input logic wrap);
        board_t nb = '0;
        for (int y = 0; y < Y; y++) begin
            for (int x = 0; x < X; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int yy = y + dy;
                        int xx = x + dx;
                        if (dy == 0 && dx == 0) continue;
                        if (wrap) begin
                            yy = (yy + Y) % Y;
                            xx = (xx + X) % X;
                        end else if (yy < 0 || yy >= Y || xx < 0 || xx >= X) begin
                            continue;
                        end
                        n += int'(b[yy][X-1-xx]);
                    end
                end
                nb[y][X-1-x] = (n == 3) || (b[y][X-1-x] && n == 2);
            end
        end
        return nb;
    endfunction

    function automatic board_t translate(input board_t b, input int dx, input int dy);
        board_t nb = '0;
        for (int y = 0; y < Y; y++)
            for (int x = 0; x < X; x++)
                nb[(y + dy) % Y][X-1-((x + dx) % X)] = b[y][X-1-x];
        return nb;
    endfunction

    task automatic load_board(input logic b, input board_t bd);
        @(negedge aclk);
        ld_bank  = b;
        ld_board = bd;
        ld_req   = 1'b1;
        @(negedge aclk);
        ld_req   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset   = 1'b0;
        exp_bank = 1'b0;
        exp_gc   = '0;
    endtask

    // One generation; start is sampled in cycle 0. Pulses/reset at given cycles (-1 = none).
    task automatic run_gen(input logic wrap, input int pulse_a, input int pulse_b, input int rst_cyc);
        int cyc, rd_n, wr_n, done_cyc;
        @(negedge aclk);
        start    = 1'b1;
        wrap_en  = wrap;
        cyc      = 0;
        rd_n     = 0;
        wr_n     = 0;
        done_cyc = -1;
        while (cyc < 30 && done_cyc < 0) begin
            @(negedge aclk);
            cyc++;
            start   = (cyc == pulse_a) || (cyc == pulse_b);
            wrap_en = ~wrap;
            if (cyc == rst_cyc) begin
                areset = 1'b1;
                #1;
                check_val("rst_busy", busy, 0);
                check_val("rst_wr_en", wr_en, 0);
                check_val("rst_rd_en", rd_en, 0);
                check_val("rst_bank_sel", bank_sel, 0);
                check_val("rst_gen_count", gen_count, 0);
                exp_bank = 1'b0;
                exp_gc   = '0;
                @(negedge aclk);
                areset = 1'b0;
                start  = 1'b0;
                return;
            end
            check_val("busy", busy, cyc <= Y + 5);
            if (rd_en) begin
                check_val("rd_cycle", cyc, rd_n + 1);
                check_val("rd_addr", rd_addr, (rd_n == 0) ? Y - 1 : rd_n - 1);
                rd_n++;
            end
            if (wr_en) begin
                check_val("wr_cycle", cyc, wr_n + 6);
                check_val("wr_addr", wr_addr, wr_n);
                wr_n++;
            end
            if (done) done_cyc = cyc;
        end
        exp_bank = ~exp_bank;
        exp_gc   = exp_gc + 32'd1;
        check_val("done_cycle", done_cyc, Y + 6);
        check_val("rd_count", rd_n, Y + 1);
        check_val("wr_count", wr_n, Y);
        check_val("bank_sel", bank_sel, exp_bank);
        check_val("gen_count", gen_count, exp_gc);
        @(negedge aclk);
        start = 1'b0;
        check_val("done_pulse_end", done, 0);
        check_val("idle_after_done", busy, 0);
    endtask

    initial begin
        board_t b;
        areset  = 1'b1;
        start   = 1'b0;
        wrap_en = 1'b0;
        ld_req  = 1'b0;
        ld_bank = 1'b0;
        ld_board = '0;
        repeat (2) @(negedge aclk);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_bank_sel", bank_sel, 0);
        check_val("reset_gen_count", gen_count, 0);
        check_val("reset_rd_en", rd_en, 0);
        check_val("reset_rd_addr", rd_addr, 0);
        check_val("reset_wr_en", wr_en, 0);
        check_val("reset_wr_addr", wr_addr, 0);
        check_val("reset_wr_data", wr_data, 0);
        areset   = 1'b0;
        exp_bank = 1'b0;
        exp_gc   = '0;

        // Blinker, dead border, and back again
        load_board(exp_bank, BLINK_H);
        run_gen(1'b0, -1, -1, -1);
        check_val("blinker_gen1", get_board(1'b1), BLINK_V);
        run_gen(1'b0, -1, -1, -1);
        check_val("blinker_gen2", get_board(1'b0), BLINK_H);

        // Corner cells: a block across the torus seam, or four lone cells
        load_board(exp_bank, CORNERS);
        run_gen(1'b1, -1, -1, -1);
        check_val("corners_wrap", get_board(exp_bank), CORNERS);
        run_gen(1'b0, -1, -1, -1);
        check_val("corners_nowrap", get_board(exp_bank), 64'h0);

        // Stray start pulses while busy and in the done cycle
        load_board(exp_bank, BLINK_H);
        run_gen(1'b0, 3, 12, -1);
        check_val("ignored_starts_board", get_board(exp_bank), life_step(BLINK_H, 1'b0));

        // Reset mid-generation, then a clean generation
        run_gen(1'b0, -1, -1, 8);
        load_board(exp_bank, PATTERN);
        run_gen(1'b1, -1, -1, -1);
        check_val("post_reset_gen", get_board(exp_bank), life_step(PATTERN, 1'b1));

        // Glider on the torus for 24 generations
        do_reset();
        load_board(exp_bank, GLIDER);
        b = GLIDER;
        for (int g = 0; g < 24; g++) begin
            run_gen(1'b1, -1, -1, -1);
            b = life_step(b, 1'b1);
            check_val("glider_step", get_board(exp_bank), b);
        end
        check_val("glider_final", get_board(exp_bank), translate(GLIDER, 6, 6));
        check_val("glider_gen_count", gen_count, 24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
